phys_reg_free_list: RTL and testbench

- Allocator/scheduler for the 64-entry physical register pool whose per-register used/ready bits live in the reservation list.
- Keeps a circular FIFO of free physical tags with a speculative head, a committed head and a tail.
- Hands one tag per cycle to rename, recycles tags released at commit, and restores on rewind.
- Drives the reservation list's reserve/free strobes so both structures stay consistent.

---
 rtl/phys_reg_pkg.sv | 28 ++
 rtl/phys_reg_free_list_if.sv | 35 +++
 rtl/phys_reg_free_list_ram.sv | 30 +++
 rtl/phys_reg_free_list.sv | 121 ++++++++++++
 tb/tb_phys_reg_free_list.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/phys_reg_pkg.sv
// Shared parameters, tag/pointer types and reset contents for the physical
// register free list.
package phys_reg_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = 6;

  typedef logic [TAG_W-1:0] phys_tag_t;
  // One extra bit so that full (distance NUM_PHYS) and empty (distance 0)
  // can be told apart.
  typedef logic [TAG_W:0]   fl_ptr_t;

  localparam fl_ptr_t PTR_ONE    = fl_ptr_t'(1);
  localparam fl_ptr_t RESET_TAIL = fl_ptr_t'(NUM_PHYS - NUM_ARCH);
  localparam fl_ptr_t PTR_FULL   = fl_ptr_t'(NUM_PHYS);

  // Slot contents after reset: the tags not mapped to architectural
  // registers, in ascending order. The remaining slots are don't-care.
  function automatic phys_tag_t reset_slot_tag(input int slot);
    if (slot < NUM_PHYS - NUM_ARCH) begin
      return phys_tag_t'(NUM_ARCH + slot);
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename / commit / reservation-list handshake bundle for the free list.
// master: the pipeline side issuing requests; slave: the free list itself.
interface phys_reg_free_list_if;
  import phys_reg_pkg::*;

  logic      en;
  logic      rewind;
  logic      alloc_req;
  logic      alloc_ready;
  phys_tag_t alloc_tag;
  logic      commit_alloc;
  // "release" is a reserved word, hence the suffix.
  logic      release_valid;
  phys_tag_t release_tag;
  fl_ptr_t   free_count;
  logic      reserve_o;
  phys_tag_t reserve_tag_o;
  logic      free_o;
  phys_tag_t free_tag_o;
  logic      overflow_err;
  logic      underflow_err;

  modport master (
    output en, rewind, alloc_req, commit_alloc, release_valid, release_tag,
    input  alloc_ready, alloc_tag, free_count, reserve_o, reserve_tag_o,
           free_o, free_tag_o, overflow_err, underflow_err
  );

  modport slave (
    input  en, rewind, alloc_req, commit_alloc, release_valid, release_tag,
    output alloc_ready, alloc_tag, free_count, reserve_o, reserve_tag_o,
           free_o, free_tag_o, overflow_err, underflow_err
  );

endinterface

// File: rtl/phys_reg_free_list_ram.sv
// Free-tag storage: NUM_PHYS x TAG_W, one synchronous write port, one
// asynchronous read port, loaded with the reset contents on reset.
module free_list_ram
  import phys_reg_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we,
  input  phys_tag_t waddr,
  input  phys_tag_t wdata,
  input  phys_tag_t raddr,
  output phys_tag_t rdata
);

  phys_tag_t mem [NUM_PHYS];

  // Reset reload of all slots, otherwise single-port write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        mem[i] <= reset_slot_tag(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free tags with a
// speculative head (rename), a committed head (retire) and a tail (release).
// Drives the reservation list reserve/free strobes in the same cycle.
// Optional build macro FREE_LIST_STATS_EN adds the stall_cycles counter port.
module phys_reg_free_list
  import phys_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  phys_reg_free_list_if.slave  fl
`ifdef FREE_LIST_STATS_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  fl_ptr_t   spec_head;
  fl_ptr_t   commit_head;
  fl_ptr_t   tail;
  fl_ptr_t   free_count_w;
  phys_tag_t head_tag;
  logic      full;
  logic      alloc_ready_w;
  logic      fire;
  logic      rel_attempt;
  logic      push;
  logic      commit_req;
  logic      commit_ok;
  logic      do_rewind;
  logic      overflow_q;
  logic      underflow_q;

  // Free tags available to rename; speculatively allocated tags are not free.
  assign free_count_w  = tail - spec_head;
  // Full is measured from the committed head: speculative tags still occupy
  // their slots until commit.
  assign full          = ((tail - commit_head) == PTR_FULL);
  assign alloc_ready_w = (free_count_w != '0) && !fl.rewind;
  assign fire          = fl.en && fl.alloc_req && alloc_ready_w;

  // p0 is permanently mapped, so releasing it is a no-op rather than an error.
  assign rel_attempt   = fl.en && fl.release_valid && (fl.release_tag != '0);
  assign push          = rel_attempt && !full;

  assign commit_req    = fl.en && fl.commit_alloc;
  assign commit_ok     = commit_req && (commit_head != spec_head);
  assign do_rewind     = fl.en && fl.rewind;

  free_list_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (tail[TAG_W-1:0]),
    .wdata (fl.release_tag),
    .raddr (spec_head[TAG_W-1:0]),
    .rdata (head_tag)
  );

  assign fl.alloc_ready   = alloc_ready_w;
  assign fl.alloc_tag     = head_tag;
  assign fl.free_count    = free_count_w;
  assign fl.reserve_o     = fire;
  assign fl.reserve_tag_o = head_tag;
  assign fl.free_o        = push;
  assign fl.free_tag_o    = fl.release_tag;
  assign fl.overflow_err  = overflow_q;
  assign fl.underflow_err = underflow_q;

  // Pointer updates; each event moves only its own pointer, rewind beats
  // allocation on spec_head and lands past a same-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= RESET_TAIL;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (commit_ok) begin
        commit_head <= commit_head + PTR_ONE;
      end
      if (do_rewind) begin
        spec_head <= commit_ok ? (commit_head + PTR_ONE) : commit_head;
      end else if (fire) begin
        spec_head <= spec_head + PTR_ONE;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (rel_attempt && full) begin
        overflow_q <= 1'b1;
      end
      if (commit_req && !commit_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

`ifdef FREE_LIST_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where rename asked but got no tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (fl.en && fl.alloc_req && !alloc_ready_w && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list. The reference model keeps the
// free list as a plain queue of tags from the committed head onward plus a
// count of speculatively handed-out entries.
module tb_phys_reg_free_list;
  import phys_reg_pkg::*;

  logic clk;
  logic reset;

  phys_reg_free_list_if fl_if ();

`ifdef FREE_LIST_STATS_EN
  logic [15:0] stall_cycles;
`endif

  phys_reg_free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl_if)
`ifdef FREE_LIST_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit chk_tag;
    int tag;
    bit ready;
    int count;
    bit ovf;
    bit unf;
    int stall;
  } status_t;

  status_t st_q[$];
  int      grant_q[$];
  int      free_q[$];

  // reference model
  int m_fifo[$];
  int m_nspec;
  bit m_ovf;
  bit m_unf;
  int m_stall;

  int total;
  int bad;

  function automatic void check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    for (int i = 0; i < NUM_PHYS - NUM_ARCH; i++) m_fifo.push_back(NUM_ARCH + i);
    m_nspec = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stall = 0;
  endfunction

  task automatic drive_idle();
    fl_if.en            = 1'b0;
    fl_if.rewind        = 1'b0;
    fl_if.alloc_req     = 1'b0;
    fl_if.commit_alloc  = 1'b0;
    fl_if.release_valid = 1'b0;
    fl_if.release_tag   = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock of stimulus; expectations come from the model's pre-edge state.
  task automatic cycle(input bit e, input bit rw, input bit ar, input bit ca,
                       input bit rv, input int rt);
    int      avail;
    bit      ready;
    bit      fire;
    bit      rel_ok;
    bit      com_ok;
    status_t s;

    fl_if.en            = e;
    fl_if.rewind        = rw;
    fl_if.alloc_req     = ar;
    fl_if.commit_alloc  = ca;
    fl_if.release_valid = rv;
    fl_if.release_tag   = phys_tag_t'(rt);

    avail  = m_fifo.size() - m_nspec;
    ready  = (avail != 0) && !rw;
    fire   = e && ar && ready;
    rel_ok = e && rv && (rt != 0) && (m_fifo.size() < NUM_PHYS);
    com_ok = e && ca && (m_nspec != 0);

    s.chk_tag = (avail != 0);
    s.tag     = (avail != 0) ? m_fifo[m_nspec] : 0;
    s.ready   = ready;
    s.count   = avail;
    s.ovf     = m_ovf;
    s.unf     = m_unf;
    s.stall   = m_stall;
    st_q.push_back(s);
    if (fire)   grant_q.push_back(m_fifo[m_nspec]);
    if (rel_ok) free_q.push_back(rt);

    if (e && ar && !ready && m_stall != 16'hFFFF) m_stall++;
    if (e && rv && (rt != 0) && !rel_ok) m_ovf = 1;
    if (e && ca && !com_ok) m_unf = 1;
    if (rel_ok) m_fifo.push_back(rt);
    if (fire) m_nspec++;
    if (com_ok) begin
      void'(m_fifo.pop_front());
      m_nspec--;
    end
    if (e && rw) m_nspec = 0;

    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge and retires expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (fl_if.reserve_o === 1'b1) begin
        if (grant_q.size() == 0) check("unexpected_reserve", 1, 0);
        else check("reserve_tag", int'(fl_if.reserve_tag_o), grant_q.pop_front());
      end else if (grant_q.size() != 0) begin
        check("missing_reserve", 0, 1);
        void'(grant_q.pop_front());
      end
      if (fl_if.free_o === 1'b1) begin
        if (free_q.size() == 0) check("unexpected_free", 1, 0);
        else check("free_tag", int'(fl_if.free_tag_o), free_q.pop_front());
      end else if (free_q.size() != 0) begin
        check("missing_free", 0, 1);
        void'(free_q.pop_front());
      end
      if (st_q.size() != 0) begin
        status_t s;
        s = st_q.pop_front();
        check("alloc_ready", int'(fl_if.alloc_ready), int'(s.ready));
        check("free_count", int'(fl_if.free_count), s.count);
        check("overflow_err", int'(fl_if.overflow_err), int'(s.ovf));
        check("underflow_err", int'(fl_if.underflow_err), int'(s.unf));
        if (s.chk_tag) check("alloc_tag", int'(fl_if.alloc_tag), s.tag);
`ifdef FREE_LIST_STATS_EN
        check("stall_cycles", int'(stall_cycles), s.stall);
`endif
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // drain all free tags, then one starved request
    for (int i = 0; i < 32; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // release into an empty list with a same-cycle request: no bypass
    cycle(1, 0, 1, 0, 1, 40);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // allocate three, commit one, rewind, reallocate
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    // rewind + commit + alloc together
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);

    // release of p0 is ignored; en=0 freezes everything
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 1, 1, 1, 1, 9);
    // commit past the speculative head -> sticky underflow
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);

    // fill to NUM_PHYS, then one more release -> sticky overflow
    for (int i = 1; i <= 33; i++) cycle(1, 0, 0, 0, 1, i);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // stall counting on an empty list
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)));
      end
    end

    drive_idle();
    @(negedge clk);
    #1;
    check("grant_q_drained", grant_q.size(), 0);
    check("free_q_drained", free_q.size(), 0);
    check("status_q_drained", st_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
